// File: rtl/mips_decode_stage.sv
// MIPS ID stage: IF/ID register, control decode, sign extension,
// load-use stall detection with bubble insertion, and branch flush.
module mips_decode_stage #(
    parameter int DW  = 32,
    parameter int RAW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           if_valid,
    input  logic [DW-1:0]  if_instr,
    input  logic [DW-1:0]  if_pc4,
    input  logic           flush,
    output logic [RAW-1:0] rf_read1,
    output logic [RAW-1:0] rf_read2,
    input  logic [DW-1:0]  rf_data1,
    input  logic [DW-1:0]  rf_data2,
    output logic           stall,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_pc4,
    output logic [DW-1:0]  ex_data1,
    output logic [DW-1:0]  ex_data2,
    output logic [DW-1:0]  ex_imm,
    output logic [RAW-1:0] ex_rs,
    output logic [RAW-1:0] ex_rt,
    output logic [RAW-1:0] ex_rd,
    output logic           ex_regdst,
    output logic           ex_alusrc,
    output logic           ex_memtoreg,
    output logic           ex_regwrite,
    output logic           ex_memread,
    output logic           ex_memwrite,
    output logic           ex_branch,
    output logic [1:0]     ex_aluop
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // Control vector layout: {regdst, alusrc, memtoreg, regwrite,
    //                         memread, memwrite, branch, aluop[1:0]}
    localparam int CW = 9;
    localparam int C_MEMREAD = 4;

    // IF/ID register
    logic           ifid_valid_q, ifid_valid_d;
    logic [DW-1:0]  ifid_instr_q, ifid_instr_d;
    logic [DW-1:0]  ifid_pc4_q,   ifid_pc4_d;

    // ID/EX register
    logic           ex_valid_q, ex_valid_d;
    logic [DW-1:0]  ex_pc4_q,   ex_pc4_d;
    logic [DW-1:0]  ex_data1_q, ex_data1_d;
    logic [DW-1:0]  ex_data2_q, ex_data2_d;
    logic [DW-1:0]  ex_imm_q,   ex_imm_d;
    logic [RAW-1:0] ex_rs_q,    ex_rs_d;
    logic [RAW-1:0] ex_rt_q,    ex_rt_d;
    logic [RAW-1:0] ex_rd_q,    ex_rd_d;
    logic [CW-1:0]  ex_ctrl_q,  ex_ctrl_d;

    // Decoded fields of the instruction currently in IF/ID
    logic [5:0]     opcode;
    logic [RAW-1:0] dec_rs, dec_rt, dec_rd;
    logic [DW-1:0]  dec_imm;
    logic [CW-1:0]  dec_ctrl;
    logic           uses_rt;
    logic           rt_match;

    assign opcode  = ifid_instr_q[31:26];
    assign dec_rs  = ifid_instr_q[25:21];
    assign dec_rt  = ifid_instr_q[20:16];
    assign dec_rd  = ifid_instr_q[15:11];
    assign dec_imm = {{(DW-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

    assign rf_read1 = dec_rs;
    assign rf_read2 = dec_rt;

    // Opcode to control bits; unknown opcodes behave as architectural NOPs
    always_comb begin
        dec_ctrl = '0;
        uses_rt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl = 9'b1_0_0_1_0_0_0_10;
                uses_rt  = 1'b1;
            end
            OP_LW:    dec_ctrl = 9'b0_1_1_1_1_0_0_00;
            OP_SW: begin
                dec_ctrl = 9'b0_1_0_0_0_1_0_00;
                uses_rt  = 1'b1;
            end
            OP_BEQ: begin
                dec_ctrl = 9'b0_0_0_0_0_0_1_01;
                uses_rt  = 1'b1;
            end
            OP_ADDI:  dec_ctrl = 9'b0_1_0_1_0_0_0_00;
            default: begin
                dec_ctrl = '0;
                uses_rt  = 1'b0;
            end
        endcase
    end

    // Load-use hazard: the load in EX writes a register this instruction
    // reads; $0 is never a real dependency. A flush makes the stall moot.
    always_comb begin
        rt_match = (ex_rt_q == dec_rs) | (uses_rt & (ex_rt_q == dec_rt));
        stall    = ifid_valid_q & ex_valid_q & ex_ctrl_q[C_MEMREAD]
                 & (ex_rt_q != '0) & rt_match & ~flush;
    end

    // IF/ID next state: flush kills, stall holds, otherwise load from IF
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
        end else if (!stall) begin
            ifid_valid_d = if_valid;
            ifid_instr_d = if_instr;
            ifid_pc4_d   = if_pc4;
        end
    end

    // ID/EX next state: bubble on flush, stall or an empty IF/ID slot
    always_comb begin
        ex_valid_d = 1'b0;
        ex_pc4_d   = '0;
        ex_data1_d = '0;
        ex_data2_d = '0;
        ex_imm_d   = '0;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        ex_rd_d    = '0;
        ex_ctrl_d  = '0;
        if (!flush && !stall && ifid_valid_q) begin
            ex_valid_d = 1'b1;
            ex_pc4_d   = ifid_pc4_q;
            ex_data1_d = rf_data1;
            ex_data2_d = rf_data2;
            ex_imm_d   = dec_imm;
            ex_rs_d    = dec_rs;
            ex_rt_d    = dec_rt;
            ex_rd_d    = dec_rd;
            ex_ctrl_d  = dec_ctrl;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ex_valid_q   <= 1'b0;
            ex_pc4_q     <= '0;
            ex_data1_q   <= '0;
            ex_data2_q   <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_ctrl_q    <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ex_valid_q   <= ex_valid_d;
            ex_pc4_q     <= ex_pc4_d;
            ex_data1_q   <= ex_data1_d;
            ex_data2_q   <= ex_data2_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_ctrl_q    <= ex_ctrl_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc4      = ex_pc4_q;
    assign ex_data1    = ex_data1_q;
    assign ex_data2    = ex_data2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_rd       = ex_rd_q;
    assign ex_regdst   = ex_ctrl_q[8];
    assign ex_alusrc   = ex_ctrl_q[7];
    assign ex_memtoreg = ex_ctrl_q[6];
    assign ex_regwrite = ex_ctrl_q[5];
    assign ex_memread  = ex_ctrl_q[4];
    assign ex_memwrite = ex_ctrl_q[3];
    assign ex_branch   = ex_ctrl_q[2];
    assign ex_aluop    = ex_ctrl_q[1:0];

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: decode table vectors, hand-written hazard,
// flush and reset sequences, then random traffic against a pipeline model.
module tb_mips_decode_stage;

    logic        clk = 1'b0;
    logic        reset, if_valid, flush;
    logic [31:0] if_instr, if_pc4, rf_data1, rf_data2;
    logic [4:0]  rf_read1, rf_read2;
    logic        stall, ex_valid;
    logic [31:0] ex_pc4, ex_data1, ex_data2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite;
    logic        ex_memread, ex_memwrite, ex_branch;
    logic [1:0]  ex_aluop;

    mips_decode_stage #(.DW(32), .RAW(5)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc4(if_pc4), .flush(flush), .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .stall(stall),
        .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_data1(ex_data1),
        .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_aluop(ex_aluop)
    );

    always #5 clk = ~clk;

    // ctrl = {regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}
    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [8:0]  ctrl;
    } ex_t;

    typedef struct {
        logic [31:0] instr;
        logic [8:0]  ctrl;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    localparam logic [31:0] I_ADD    = 32'h00221820; // add $3,$1,$2
    localparam logic [31:0] I_ADDI_N = 32'h2004FFFF; // addi $4,$0,-1
    localparam logic [31:0] I_LW2    = 32'h8C220000; // lw $2,0($1)
    localparam logic [31:0] I_ADD_U  = 32'h00451820; // add $3,$2,$5
    localparam logic [31:0] I_ADDI67 = 32'h20E60001; // addi $6,$7,1
    localparam logic [31:0] I_LW0    = 32'h8C200000; // lw $0,0($1)
    localparam logic [31:0] I_ADD00  = 32'h00001820; // add $3,$0,$0

    logic [31:0] regfile [32];
    assign rf_data1 = regfile[rf_read1];
    assign rf_data2 = regfile[rf_read2];

    int n_cmp = 0;
    int n_err = 0;
    int stall_seen = 0;
    logic last_dut_stall;

    // Reference pipeline state
    logic        m_ifid_v;
    logic [31:0] m_ifid_i, m_ifid_p;
    ex_t         m_ex;
    logic        m_stall;

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b1_0_0_1_0_0_0_10;
            6'h23:   return 9'b0_1_1_1_1_0_0_00;
            6'h2B:   return 9'b0_1_0_0_0_1_0_00;
            6'h04:   return 9'b0_0_0_0_0_0_1_01;
            6'h08:   return 9'b0_1_0_1_0_0_0_00;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic reads_rt(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    endfunction

    function automatic ex_t decode_model(input logic [31:0] i, input logic [31:0] p);
        ex_t e;
        e.valid = 1'b1;
        e.pc4   = p;
        e.d1    = regfile[i[25:21]];
        e.d2    = regfile[i[20:16]];
        e.imm   = 32'(int'($signed(i[15:0])));
        e.rs    = i[25:21];
        e.rt    = i[20:16];
        e.rd    = i[15:11];
        e.ctrl  = ctrl_of(i[31:26]);
        return e;
    endfunction

    function automatic ex_t dut_ex();
        ex_t a;
        a = {ex_valid, ex_pc4, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_rd,
             ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
             ex_memwrite, ex_branch, ex_aluop};
        return a;
    endfunction

    // One clock: drive inputs, check combinational outputs mid-cycle,
    // advance the model at the edge, then check the ID/EX outputs.
    task automatic cyc(input logic rst, input logic v, input logic [31:0] ins,
                       input logic [31:0] p4, input logic fl, input bit chk_comb);
        ex_t         n_ex;
        logic        n_v;
        logic [31:0] n_i, n_p;
        logic [4:0]  rs, rt;
        reset = rst; if_valid = v; if_instr = ins; if_pc4 = p4; flush = fl;
        #4;
        rs = m_ifid_i[25:21];
        rt = m_ifid_i[20:16];
        m_stall = !fl && m_ifid_v && m_ex.valid && m_ex.ctrl[4] && (m_ex.rt != 5'd0)
                  && ((m_ex.rt == rs) || (reads_rt(m_ifid_i[31:26]) && m_ex.rt == rt));
        last_dut_stall = stall;
        if (stall === 1'b1) stall_seen++;
        if (chk_comb) begin
            check("stall", 160'(stall), 160'(m_stall));
            check("rf_read1", 160'(rf_read1), 160'(rs));
            check("rf_read2", 160'(rf_read2), 160'(rt));
        end
        if (rst) begin
            n_ex = '0; n_v = 1'b0; n_i = '0; n_p = '0;
        end else begin
            n_ex = (fl || m_stall || !m_ifid_v) ? '0 : decode_model(m_ifid_i, m_ifid_p);
            if (fl) begin
                n_v = 1'b0; n_i = '0; n_p = '0;
            end else if (m_stall) begin
                n_v = m_ifid_v; n_i = m_ifid_i; n_p = m_ifid_p;
            end else begin
                n_v = v; n_i = ins; n_p = p4;
            end
        end
        @(posedge clk);
        #1;
        m_ex = n_ex; m_ifid_v = n_v; m_ifid_i = n_i; m_ifid_p = n_p;
        check("ex_stage", 160'(dut_ex()), 160'(m_ex));
    endtask

    task automatic nop();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    vec_t vecs [7];
    logic        cv;
    logic [31:0] ci, cp;

    task automatic new_instr();
        logic [5:0] op;
        int sel;
        sel = $urandom_range(0, 6);
        case (sel)
            0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B; 3: op = 6'h04;
            4: op = 6'h08; 5: op = 6'h3F; default: op = 6'($urandom);
        endcase
        cv = ($urandom_range(0, 99) < 85);
        ci = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
        cp = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regfile[i] = 32'hA500_0000 | 32'(i);
        regfile[0] = 32'h0;
        regfile[1] = 32'd5;
        regfile[2] = 32'd7;
        m_ifid_v = 1'b0; m_ifid_i = '0; m_ifid_p = '0; m_ex = '0; m_stall = 1'b0;

        vecs[0] = '{I_ADD,       9'b1_0_0_1_0_0_0_10, 32'h00001820, 5'd2, 5'd3,  32'd5, 32'd7};
        vecs[1] = '{I_ADDI_N,    9'b0_1_0_1_0_0_0_00, 32'hFFFFFFFF, 5'd4, 5'd31, 32'd0, 32'hA5000004};
        vecs[2] = '{I_LW2,       9'b0_1_1_1_1_0_0_00, 32'h00000000, 5'd2, 5'd0,  32'd5, 32'd7};
        vecs[3] = '{32'hAC220004, 9'b0_1_0_0_0_1_0_00, 32'h00000004, 5'd2, 5'd0,  32'd5, 32'd7};
        vecs[4] = '{32'h10220003, 9'b0_0_0_0_0_0_1_01, 32'h00000003, 5'd2, 5'd0,  32'd5, 32'd7};
        vecs[5] = '{32'h1022FFFE, 9'b0_0_0_0_0_0_1_01, 32'hFFFFFFFE, 5'd2, 5'd31, 32'd5, 32'd7};
        vecs[6] = '{32'hFC000000, 9'b0,               32'h00000000, 5'd0, 5'd0,  32'd0, 32'd0};

        // Reset held two cycles with a valid instruction at the input
        cyc(1'b1, 1'b1, I_ADD, 32'h100, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, I_ADD, 32'h100, 1'b0, 1'b1);
        check("rst_stall", 160'(stall), 160'(0));
        cyc(1'b0, 1'b1, I_ADD, 32'h104, 1'b0, 1'b1);
        check("rst_first_edge_valid", 160'(ex_valid), 160'(0));
        nop();
        check("rst_second_edge_valid", 160'(ex_valid), 160'(1));
        check("rst_second_edge_pc4", 160'(ex_pc4), 160'(32'h104));
        nop();

        // Decode table
        for (int k = 0; k < 7; k++) begin
            cyc(1'b0, 1'b1, vecs[k].instr, 32'h200 + 32'(k * 4), 1'b0, 1'b1);
            nop();
            check("tbl_valid", 160'(ex_valid), 160'(1));
            check("tbl_ctrl", 160'(dut_ex().ctrl), 160'(vecs[k].ctrl));
            check("tbl_imm", 160'(ex_imm), 160'(vecs[k].imm));
            check("tbl_rt", 160'(ex_rt), 160'(vecs[k].rt));
            check("tbl_rd", 160'(ex_rd), 160'(vecs[k].rd));
            check("tbl_data1", 160'(ex_data1), 160'(vecs[k].d1));
            check("tbl_data2", 160'(ex_data2), 160'(vecs[k].d2));
        end
        nop();
        check("invalid_gives_bubble", 160'(ex_valid), 160'(0));

        // Load-use: lw $2 then add $3,$2,$5
        cyc(1'b0, 1'b1, I_LW2, 32'h300, 1'b0, 1'b1);
        stall_seen = 0;
        cyc(1'b0, 1'b1, I_ADD_U, 32'h304, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, I_ADD_U, 32'h304, 1'b0, 1'b1);
        check("lu_stall_cycle", 160'(last_dut_stall), 160'(1));
        check("lu_bubble", 160'(dut_ex()), 160'(0));
        nop();
        check("lu_issue_valid", 160'(ex_valid), 160'(1));
        check("lu_issue_rs", 160'(ex_rs), 160'(2));
        check("lu_stall_count", 160'(stall_seen), 160'(1));
        nop();

        // lw $2 then addi $6,$7,1: rt is not read by addi
        cyc(1'b0, 1'b1, I_LW2, 32'h310, 1'b0, 1'b1);
        stall_seen = 0;
        cyc(1'b0, 1'b1, I_ADDI67, 32'h314, 1'b0, 1'b1);
        nop(); nop();
        check("lw_addi_nostall", 160'(stall_seen), 160'(0));

        // lw $0 then add $3,$0,$0: $0 never stalls
        cyc(1'b0, 1'b1, I_LW0, 32'h320, 1'b0, 1'b1);
        stall_seen = 0;
        cyc(1'b0, 1'b1, I_ADD00, 32'h324, 1'b0, 1'b1);
        nop(); nop();
        check("lw0_nostall", 160'(stall_seen), 160'(0));

        // Flush during the load-use stall cycle
        cyc(1'b0, 1'b1, I_LW2, 32'h330, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, I_ADD_U, 32'h334, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, I_ADD_U, 32'h334, 1'b1, 1'b1);
        check("flush_stall_out", 160'(last_dut_stall), 160'(0));
        check("flush_stall_exv", 160'(ex_valid), 160'(0));
        cyc(1'b0, 1'b1, I_ADDI67, 32'h400, 1'b0, 1'b1);
        check("flush_stall_ifid_cleared", 160'(ex_valid), 160'(0));
        nop();
        check("post_flush_issue", 160'(ex_valid), 160'(1));
        check("post_flush_rt", 160'(ex_rt), 160'(6));

        // Flush with no hazard
        cyc(1'b0, 1'b1, I_ADD, 32'h410, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, I_ADDI67, 32'h414, 1'b1, 1'b1);
        check("flush_plain_exv", 160'(ex_valid), 160'(0));
        nop();
        check("flush_plain_ifid_cleared", 160'(ex_valid), 160'(0));

        // Reset in the middle of a stall
        cyc(1'b0, 1'b1, I_LW2, 32'h420, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, I_ADD_U, 32'h424, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, I_ADD_U, 32'h424, 1'b0, 1'b1);
        check("rst_mid_exv", 160'(ex_valid), 160'(0));
        nop();
        check("rst_mid_stall", 160'(last_dut_stall), 160'(0));
        check("rst_mid_exv2", 160'(ex_valid), 160'(0));

        // Random traffic; IF re-presents the same instruction while stalled
        new_instr();
        for (int k = 0; k < 2000; k++) begin
            logic rst, fl;
            rst = ($urandom_range(0, 49) == 0);
            fl  = ($urandom_range(0, 11) == 0);
            cyc(rst, cv, ci, cp, fl, 1'b1);
            if (!m_stall || fl || rst) new_instr();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
